cnf_skolem_search: RTL

Sequential Skolem-witness search engine for CNF specifications over NX universal inputs and NY existential outputs. It holds a clause store of up to NC clauses, latches a universal assignment x, then enumerates candidate y values in ascending order, one per cycle. It stops at the first y that satisfies every valid clause. It sits behind the combinational per-instance netlists as the generic, runtime-loadable fallback: one engine serves any formula that fits the parameters.

---
 rtl/cnf_skolem_search.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cnf_skolem_search.sv
// ============================================================================
// Module   : cnf_skolem_search
// Purpose  : Runtime-loadable CNF Skolem-witness search. Latches x, scans y
//            upward one candidate per cycle, stops on the first satisfying y.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cnf_skolem_search #(
    parameter int NX = 2,
    parameter int NY = 2,
    parameter int NC = 8,
    localparam int NV = NX + NY,
    localparam int AW = $clog2(NC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cl_we,
    input  logic [AW-1:0] cl_addr,
    input  logic [NV-1:0] cl_pos,
    input  logic [NV-1:0] cl_neg,
    input  logic          cl_clr,
    input  logic          start,
    input  logic [NX-1:0] x_in,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [NY-1:0] y_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [NX-1:0] r_x;
    logic [NY-1:0] r_cand;
    logic          r_found;
    logic [NY-1:0] r_y;

    logic [NC-1:0] r_valid;
    logic [NV-1:0] r_pos [NC];
    logic [NV-1:0] r_neg [NC];

    logic [NV-1:0] w_v;
    logic [NC-1:0] w_clause_sat;
    logic          w_sat;
    logic          w_last;
    logic          w_store_open;
    logic          w_wr;

    logic          w_launch;
    logic          w_hit;
    logic          w_miss;
    logic          w_step;

    // Store is frozen while a search runs; a clear always beats a write.
    assign w_store_open = (r_state != S_SEARCH);
    assign w_wr         = w_store_open && cl_we && !cl_clr && (int'(cl_addr) < NC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_store_open && cl_clr) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[cl_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pos[cl_addr] <= cl_pos;
            r_neg[cl_addr] <= cl_neg;
        end
    end

    assign w_v = {r_cand, r_x};

    generate
        for (genvar c = 0; c < NC; c++) begin : g_clause
            assign w_clause_sat[c] = !r_valid[c] || (|((r_pos[c] & w_v) | (r_neg[c] & ~w_v)));
        end
    endgenerate

    assign w_sat  = &w_clause_sat;
    assign w_last = (r_cand == {NY{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_sat) begin
                    w_hit       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_last) begin
                    w_miss      = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_step      = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_SEARCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_cand  <= '0;
            r_found <= 1'b0;
            r_y     <= '0;
        end else if (w_launch) begin
            r_x     <= x_in;
            r_cand  <= '0;
            r_found <= 1'b0;
            r_y     <= '0;
        end else if (w_hit) begin
            r_found <= 1'b1;
            r_y     <= r_cand;
        end else if (w_miss) begin
            r_found <= 1'b0;
            r_y     <= '0;
        end else if (w_step) begin
            r_cand  <= r_cand + 1'b1;
        end
    end

    assign busy  = (r_state == S_SEARCH);
    assign done  = (r_state == S_DONE);
    assign found = r_found;
    assign y_out = r_y;

endmodule

`default_nettype wire
